// File: rtl/i2s_transmitter.sv
// rtl/i2s_transmitter.sv - I2S serializer with single-entry sample buffer and sticky underrun flag
module i2s_transmitter #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_BITS    = 32,
  parameter int BCLK_DIV     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] left_data,
  input  logic [SAMPLE_WIDTH-1:0] right_data,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  input  logic                    underrun_clr,
  output logic                    underrun,
  output logic                    frame_start,
  output logic                    dac_bclk,
  output logic                    dac_lrclk,
  output logic                    dac_data
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CNT_W      = ($clog2(FRAME_BITS) > 6) ? $clog2(FRAME_BITS) : 6;
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  // Zero bits after the sample inside a slot; the slot's first bit is the I2S delay bit.
  localparam int PAD        = SLOT_BITS - SAMPLE_WIDTH - 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_BITS);

  logic [DIV_W-1:0]        div_q, div_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    bclk_q, bclk_d;
  logic                    lrclk_q, lrclk_d;
  logic                    data_q, data_d;
  logic                    fs_q, fs_d;
  logic                    und_q, und_d;
  logic                    full_q, full_d;
  logic [SAMPLE_WIDTH-1:0] pend_l_q, pend_l_d;
  logic [SAMPLE_WIDTH-1:0] pend_r_q, pend_r_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [FRAME_BITS-1:0]   load_frame;
  logic [SLOT_BITS-1:0]    l_slot, r_slot;
  logic                    tick, fall, boundary, accept;

  assign tick     = (div_q == DIV_LAST);
  assign fall     = enable && tick && bclk_q;
  assign boundary = fall && (cnt_q == CNT_LAST);

  assign sample_ready = enable && !full_q && !reset;
  assign accept       = sample_valid && sample_ready;

  // Frame image in transmit order: MSB of load_frame goes out at bit_cnt 0.
  assign l_slot     = {{(SLOT_BITS - SAMPLE_WIDTH){1'b0}}, pend_l_q} << PAD;
  assign r_slot     = {{(SLOT_BITS - SAMPLE_WIDTH){1'b0}}, pend_r_q} << PAD;
  assign load_frame = full_q ? {l_slot, r_slot} : '0;

  assign dac_bclk    = bclk_q;
  assign dac_lrclk   = lrclk_q;
  assign dac_data    = data_q;
  assign frame_start = fs_q;
  assign underrun    = und_q;

  // Next-state: divider, bit clock, serializer, pending buffer and underrun flag.
  always_comb begin
    div_d    = div_q;
    cnt_d    = cnt_q;
    bclk_d   = bclk_q;
    lrclk_d  = lrclk_q;
    data_d   = data_q;
    fs_d     = 1'b0;
    full_d   = full_q;
    pend_l_d = pend_l_q;
    pend_r_d = pend_r_q;
    shift_d  = shift_q;
    und_d    = und_q;

    if (!enable) begin
      div_d   = '0;
      cnt_d   = CNT_LAST;
      bclk_d  = 1'b0;
      lrclk_d = 1'b0;
      data_d  = 1'b0;
      full_d  = 1'b0;
      shift_d = '0;
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        bclk_d = ~bclk_q;
      end
      if (fall) begin
        cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        lrclk_d = (cnt_d >= CNT_SLOT);
        if (boundary) begin
          // Bit 0 of every frame is the delay bit and is always zero.
          data_d  = 1'b0;
          shift_d = load_frame << 1;
          fs_d    = 1'b1;
          full_d  = 1'b0;
        end else begin
          data_d  = shift_q[FRAME_BITS-1];
          shift_d = shift_q << 1;
        end
      end
      // An accept in the boundary clk lands after the buffer was sampled, so it waits a frame.
      if (accept) begin
        full_d   = 1'b1;
        pend_l_d = left_data;
        pend_r_d = right_data;
      end
    end

    if (boundary && !full_q) begin
      und_d = 1'b1;
    end else if (underrun_clr) begin
      und_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= '0;
      cnt_q    <= CNT_LAST;
      bclk_q   <= 1'b0;
      lrclk_q  <= 1'b0;
      data_q   <= 1'b0;
      fs_q     <= 1'b0;
      und_q    <= 1'b0;
      full_q   <= 1'b0;
      pend_l_q <= '0;
      pend_r_q <= '0;
      shift_q  <= '0;
    end else begin
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      bclk_q   <= bclk_d;
      lrclk_q  <= lrclk_d;
      data_q   <= data_d;
      fs_q     <= fs_d;
      und_q    <= und_d;
      full_q   <= full_d;
      pend_l_q <= pend_l_d;
      pend_r_q <= pend_r_d;
      shift_q  <= shift_d;
    end
  end

endmodule

// File: doc/i2s_transmitter.md
I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001 Parameter SAMPLE_WIDTH, default 24: bits per channel sample, MSB first; legal range 16..SLOT_BITS-1.
REQ-002 Parameter SLOT_BITS, default 32: bclk periods per channel slot; frame = 2*SLOT_BITS bclk periods.
REQ-003 Parameter BCLK_DIV, default 4: clk cycles per bclk half-period; legal values >= 1.
REQ-004 clk  in  1  system clock; all logic rising-edge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  1 = run the serializer; 0 = hold idle.
REQ-007 left_data  in  SAMPLE_WIDTH  left sample, two's complement.
REQ-008 right_data  in  SAMPLE_WIDTH  right sample, two's complement.
REQ-009 sample_valid  in  1  left_data/right_data valid.
REQ-010 sample_ready  out  1  pending buffer empty; a sample is accepted on clk where sample_valid && sample_ready.
REQ-011 underrun_clr  in  1  clears underrun.
REQ-012 underrun  out  1  sticky: a frame started with no pending sample.
REQ-013 frame_start  out  1  one-clk pulse at each frame boundary.
REQ-014 dac_bclk, dac_lrclk, dac_data  out  1 each  I2S bit clock, word select (0 = left), serial data.

Function
REQ-015 Divider counts 0..BCLK_DIV-1 while enable=1; at terminal count it wraps and dac_bclk toggles: 0->1 is a rise event, 1->0 is a fall event.
REQ-016 dac_lrclk, dac_data and the 6-bit-or-wider bit counter change only on fall events, in the same clk as dac_bclk goes low.
REQ-017 On each fall event, bit_cnt increments modulo 2*SLOT_BITS; dac_lrclk = 0 when new bit_cnt < SLOT_BITS, else 1.
REQ-018 Standard I2S one-bit delay: at bit_cnt = k (1 <= k <= SAMPLE_WIDTH), dac_data = left[SAMPLE_WIDTH-k]; at bit_cnt = SLOT_BITS+k, dac_data = right[SAMPLE_WIDTH-k]; all other bit_cnt values output 0.
REQ-019 Single-entry pending buffer: on accept, left/right are copied into it, making it full; sample_ready = enable && !full.
REQ-020 Frame boundary is the fall event at which bit_cnt becomes 0; in that clk frame_start = 1 for exactly one clk.
REQ-021 At frame boundary with buffer full: pending moves to the shift register and the buffer empties, so sample_ready returns to 1 on the next clk.
REQ-022 At frame boundary with buffer empty: the frame transmits all zeros, and underrun is set.
REQ-023 Accept and frame boundary in the same clk with buffer empty: underrun is set, the frame is zero, and the new sample stays pending for the next frame.
REQ-024 underrun_clr and an underrun set event in the same clk: set wins.
REQ-025 Latency: a sample accepted before a boundary produces its left MSB on dac_data at the next fall event after that boundary.
REQ-026 enable=0, including mid-frame: on the next clk divider=0, bit_cnt=2*SLOT_BITS-1, dac_bclk/dac_lrclk/dac_data=0 and the pending buffer is emptied; underrun is held.
REQ-027 On enable 0->1, the first divider terminal count is a rise event, and the first fall event is a frame boundary.

Reset
REQ-028 On reset: divider=0, bit_cnt=2*SLOT_BITS-1, buffer empty, shift register=0; dac_bclk, dac_lrclk, dac_data, sample_ready, frame_start and underrun all 0.
REQ-029 Reset asserted mid-frame: state is as REQ-028 on the next clk, regardless of enable or sample_valid.

Verification (BCLK_DIV=2, SAMPLE_WIDTH=24, SLOT_BITS=32)
REQ-030 Set enable=1 and hold it -> dac_bclk period 4 clk, 50% duty; dac_lrclk period 256 clk; frame_start every 256 clk.
REQ-031 Accept left=0xA5A5A5, right=0x5A5A5A before the first boundary -> bits 1..24 carry A5A5A5 MSB-first, and bits 33..56 carry 5A5A5A; all other bits are 0; dac_lrclk toggles one bclk before each MSB.
REQ-032 Keep sample_valid=1 continuously with incrementing values -> exactly one accept per frame, no sample skipped or repeated, underrun stays 0.
REQ-033 Supply no sample for one frame -> that frame is all zeros and underrun=1; pulse underrun_clr -> underrun=0; underrun_clr in the same clk as a new underrun -> underrun stays 1.
REQ-034 Accept a sample in the exact clk of frame_start with the buffer empty -> underrun=1, and the sample is transmitted in the following frame.
REQ-035 Deassert enable at bit_cnt=40, or assert reset at bit_cnt=40 -> next clk all outputs 0 and the buffer empty; re-enable -> a clean frame starts with left MSB at the first bit_cnt=1.
